edge_event_capture: RTL and testbench
=====================================

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4, stable cycles required before a level change is accepted (legal 1..255).
REQ-002 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, event queue depth (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sync_in  input  1  level already synchronized into the clk domain by the upstream 2-flop stage.
REQ-007 SHALL have port clear  input  1  synchronous clear of queue, overflow and timestamp.
REQ-008 SHALL have port level  output  1  filtered (debounced) level.
REQ-009 SHALL have port evt_valid  output  1  queue head holds an event.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port evt_type  output  1  head event type: 1 = rising, 0 = falling.
REQ-012 SHALL have port evt_ts  output  TS_W  head event timestamp.
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped.

Function
REQ-014 SHALL run a free-running TS_W-bit timestamp counter, +1 every cycle, wrapping from all-ones to 0.
REQ-015 SHALL count consecutive cycles where sync_in != level; counter resets to 0 on any cycle sync_in == level.
REQ-016 SHALL toggle level when that count reaches FILT_LEN, so a clean sync_in change appears on level exactly FILT_LEN cycles later; shorter pulses never reach level.
REQ-017 SHALL, on the cycle level toggles, push one record {type = new level, ts = timestamp value in that cycle} into the queue.
REQ-018 SHALL hold evt_valid high whenever the queue is non-empty; evt_type/evt_ts show the oldest record.
REQ-019 SHALL pop the head on a cycle with evt_valid && evt_ready; head outputs stay stable while evt_valid && !evt_ready.
REQ-020 SHALL, when full and no pop occurs, discard the new record and set overflow (held until clear or reset).
REQ-021 SHALL, when full with push and pop in the same cycle, accept both; overflow unchanged.
REQ-022 SHALL, when empty with a push, present the record with evt_valid high the following cycle (no fall-through).
REQ-023 SHALL, on clear, empty the queue, clear overflow and load timestamp to 0 in the next cycle; level and filter counter unaffected.
REQ-024 SHALL give clear priority over a same-cycle push and pop: the record is discarded, overflow not set.

Reset
REQ-025 SHALL, while rst low, force level=0, evt_valid=0, evt_type=0, evt_ts=0, overflow=0, timestamp=0, filter count=0, queue empty.
REQ-026 SHALL, on reset asserted mid-operation, discard all queued events immediately; no partial record survives.
REQ-027 SHALL, after rst deasserts with sync_in=1, generate a rising event after FILT_LEN cycles.

Configuration
REQ-028 SHALL, when macro EDGE_EVENT_COUNT_EN is defined, add output evt_count [15:0]: count of records accepted into the queue, saturating at 16'hFFFF, zeroed by clear and reset.
REQ-029 SHALL, when EDGE_EVENT_COUNT_EN is undefined, omit evt_count port and logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: FILT_LEN=4, sync_in 0->1 held -> level=1 exactly 4 cycles later; evt_valid next cycle, evt_type=1, evt_ts = ts at toggle cycle.
REQ-031 SHALL cover: 3-cycle pulse on sync_in, FILT_LEN=4 -> level stays 0, no event, evt_valid stays 0.
REQ-032 SHALL cover: DEPTH=4, evt_ready=0, 5 clean edges -> 4 records held in order, overflow=1, 5th lost; then drain -> types alternate 1,0,1,0.
REQ-033 SHALL cover: queue full, edge and evt_ready=1 same cycle -> overflow stays 0, queue stays at 4 entries.
REQ-034 SHALL cover: clear together with edge push -> queue empty, overflow 0, timestamp 0 next cycle, level still updated.
REQ-035 SHALL cover: TS_W=4, event across wrap -> ts values 15 then 0 accepted; with EDGE_EVENT_COUNT_EN, evt_count increments per accepted record only.

Source files
------------

// File: rtl/edge_event_capture.sv
// ---------------------------------------------------------------------------
// edge_event_capture
//
// Debounces an already-synchronized input level and records every accepted
// level change as a timestamped event in a small FIFO.
//
// Parameters
//   FILT_LEN : consecutive disagreeing cycles needed to accept a change (1..255)
//   TS_W     : timestamp width
//   DEPTH    : event queue depth (power of two, 2..16)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   sync_in    in   synchronized input level
//   clear      in   synchronous clear of queue, overflow flag and timestamp
//   level      out  filtered level
//   evt_valid  out  queue head holds an event
//   evt_ready  in   consumer accepts the head this cycle
//   evt_type   out  head event type (1 = rising, 0 = falling)
//   evt_ts     out  head event timestamp
//   overflow   out  sticky flag: an event was dropped because the queue was full
//   evt_count  out  (only with EDGE_EVENT_COUNT_EN) saturating count of
//                   records accepted into the queue
//
// Optional feature macro: EDGE_EVENT_COUNT_EN
// ---------------------------------------------------------------------------
module edge_event_capture #(
    parameter int FILT_LEN = 4,
    parameter int TS_W     = 16,
    parameter int DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sync_in,
    input  logic            clear,
    output logic            level,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic            evt_type,
    output logic [TS_W-1:0] evt_ts,
`ifdef EDGE_EVENT_COUNT_EN
    output logic [15:0]     evt_count,
`endif
    output logic            overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0]      FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [TS_W-1:0] TS_ONE    = TS_W'(1);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);

    logic [TS_W-1:0] ts_q, ts_d;
    logic [7:0]      filt_cnt_q, filt_cnt_d;
    logic            level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            mem_type_q [DEPTH];
    logic            mem_type_d [DEPTH];
    logic [TS_W-1:0] mem_ts_q   [DEPTH];
    logic [TS_W-1:0] mem_ts_d   [DEPTH];

    logic toggle;
    logic pop;
    logic accept;
    logic wr_en;
    logic full;

    // Filter, timestamp and queue bookkeeping.
    always_comb begin
        level_d    = level_q;
        filt_cnt_d = 8'd0;
        toggle     = 1'b0;
        // The counter tracks consecutive disagreeing cycles; the cycle that
        // would bring it to FILT_LEN flips the level instead.
        if (sync_in != level_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end

        full   = (count_q == DEPTH_C);
        pop    = (count_q != '0) && evt_ready;
        // A full queue can still take a record if the head leaves this cycle.
        accept = toggle && (!full || pop);

        ts_d       = ts_q + TS_ONE;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        if (clear) begin
            // Clear wins over any same-cycle push or pop.
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (accept) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (toggle && !accept) begin
                overflow_d = 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            filt_cnt_q <= '0;
            level_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            filt_cnt_q <= filt_cnt_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: head outputs are gated by evt_valid, so stale
    // contents are never visible after reset or clear.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                mem_type_d[gi] = mem_type_q[gi];
                mem_ts_d[gi]   = mem_ts_q[gi];
                if (wr_en && (wr_ptr_q == AW'(gi))) begin
                    mem_type_d[gi] = level_d;
                    mem_ts_d[gi]   = ts_q;
                end
            end

            always_ff @(posedge clk) begin
                mem_type_q[gi] <= mem_type_d[gi];
                mem_ts_q[gi]   <= mem_ts_d[gi];
            end
        end
    endgenerate

`ifdef EDGE_EVENT_COUNT_EN
    logic [15:0] evt_count_q, evt_count_d;

    always_comb begin
        evt_count_d = evt_count_q;
        if (clear) begin
            evt_count_d = 16'd0;
        end else if (accept && (evt_count_q != 16'hFFFF)) begin
            evt_count_d = evt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_count_q <= 16'd0;
        end else begin
            evt_count_q <= evt_count_d;
        end
    end

    assign evt_count = evt_count_q;
`endif

    assign level     = level_q;
    assign evt_valid = (count_q != '0);
    assign evt_type  = evt_valid & mem_type_q[rd_ptr_q];
    assign evt_ts    = evt_valid ? mem_ts_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// ---------------------------------------------------------------------------
// tb_edge_event_capture
//
// Randomized plus directed stimulus against a behavioural model. The model
// decides a level change by looking at the window of samples seen since the
// last change, and keeps the event queue as an SV queue. Accepted records go
// to a scoreboard; a monitor pops it on every DUT handshake.
// ---------------------------------------------------------------------------
module tb_edge_event_capture;

    localparam int F  = 4;
    localparam int TW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sync_in = 1'b0;
    logic          clear = 1'b0;
    logic          evt_ready = 1'b0;
    logic          level;
    logic          evt_valid;
    logic          evt_type;
    logic [TW-1:0] evt_ts;
    logic          overflow;
`ifdef EDGE_EVENT_COUNT_EN
    logic [15:0]   evt_count;
`endif

    edge_event_capture #(
        .FILT_LEN (F),
        .TS_W     (TW),
        .DEPTH    (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .clear     (clear),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_ts    (evt_ts),
`ifdef EDGE_EVENT_COUNT_EN
        .evt_count (evt_count),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit t;
        int ts;
    } rec_t;

    bit   m_level;
    bit   m_recent[$];   // samples since the last accepted level change
    rec_t m_q[$];        // model queue contents
    rec_t sb_q[$];       // scoreboard of records awaiting DUT handshake
    int   m_ts;
    bit   m_ovf;
    int   m_cnt;

    function automatic void model_reset();
        m_level = 1'b0;
        m_recent.delete();
        m_q.delete();
        sb_q.delete();
        m_ts  = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(bit s, bit r, bit c);
        bit   tog;
        bit   pop;
        rec_t rc;
        m_recent.push_back(s);
        if (m_recent.size() > F) void'(m_recent.pop_front());
        // A change is accepted once the last F samples all disagree with the level.
        tog = (m_recent.size() == F);
        foreach (m_recent[i]) if (m_recent[i] == m_level) tog = 1'b0;
        pop   = (m_q.size() > 0) && r;
        rc.t  = !m_level;
        rc.ts = m_ts;
        if (tog) begin
            m_level = !m_level;
            m_recent.delete();
        end
        if (c) begin
            m_q.delete();
            sb_q.delete();
            m_ovf = 1'b0;
            m_ts  = 0;
            m_cnt = 0;
        end else begin
            m_ts = (m_ts + 1) % (1 << TW);
            if (pop) void'(m_q.pop_front());
            if (tog) begin
                if (m_q.size() < D) begin
                    m_q.push_back(rc);
                    sb_q.push_back(rc);
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endfunction

    // One clock: inputs applied now, model advanced right after the edge.
    task automatic cyc(input bit s, input bit r, input bit c);
        sync_in   = s;
        evt_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
        if (rst) model_step(s, r, c);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rec_t e;
        if (!rst) begin
            check("rst_level", int'(level), 0);
            check("rst_valid", int'(evt_valid), 0);
            check("rst_type", int'(evt_type), 0);
            check("rst_ts", int'(evt_ts), 0);
            check("rst_overflow", int'(overflow), 0);
`ifdef EDGE_EVENT_COUNT_EN
            check("rst_count", int'(evt_count), 0);
`endif
        end else begin
            check("level", int'(level), int'(m_level));
            check("evt_valid", int'(evt_valid), int'(m_q.size() > 0));
            check("overflow", int'(overflow), int'(m_ovf));
`ifdef EDGE_EVENT_COUNT_EN
            check("evt_count", int'(evt_count), m_cnt);
`endif
            if (evt_valid && evt_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got handshake type=%0d ts=%0d required no record", evt_type, evt_ts);
                end else begin
                    e = sb_q.pop_front();
                    check("evt_type", int'(evt_type), int'(e.t));
                    check("evt_ts", int'(evt_ts), e.ts);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit s;
        int hold;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Release reset with the input already high: rising event after F cycles.
        s   = 1'b1;
        sync_in = 1'b1;
        rst = 1'b1;
        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (2) cyc(1, 0, 0);

        // Short pulse (F-1 cycles) must not reach level.
        repeat (F - 1) cyc(0, 0, 0);
        repeat (6) cyc(1, 0, 0);
        // Return low so the overflow run starts with a rising edge.
        repeat (6) cyc(0, 0, 0);
        cyc(0, 0, 1);

        // Five edges with no consumer: four kept, fifth dropped, overflow set.
        s = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s = !s;
            repeat (6) cyc(s, 0, 0);
        end
        repeat (6) cyc(s, 1, 0);

        // Full queue, edge arriving on the same cycle as a pop.
        cyc(s, 0, 1);
        for (int k = 0; k < 4; k++) begin
            s = !s;
            repeat (6) cyc(s, 0, 0);
        end
        s = !s;
        repeat (F - 1) cyc(s, 0, 0);
        cyc(s, 1, 0);
        repeat (3) cyc(s, 0, 0);
        repeat (8) cyc(s, 1, 0);

        // Clear coinciding with an edge push.
        s = !s;
        repeat (F - 1) cyc(s, 0, 0);
        cyc(s, 0, 1);
        repeat (4) cyc(s, 1, 0);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b0;
                model_reset();
                repeat (3) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                rst = 1'b1;
            end
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) s = !s;
            for (int h = 0; h < hold; h++) begin
                cyc(s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        repeat (3) cyc(s, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
